// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and TX FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte FIFO storage for the UART transmit buffer: RAM, wrap-bit pointers and FULL/EMPTY decode.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    input  logic                   i_pop,
    output logic [UART_DATA_W-1:0] o_rd_data,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic                   w_push;
    logic                   w_pop;

    // The extra MSB separates "all entries used" from "none used" when addresses match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // RAM write port; contents are not reset so the array maps onto plain memory.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Write and read pointers, wrapping modulo 2^(AW+1).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART START/DATA_TX/READY_TX handshake.
// Optional sticky overflow flag (o_ovf/i_ovf_clr) enabled by macro UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    output logic                   o_full,
    output logic                   o_empty,
    input  logic                   i_uart_ready_tx,
    output logic                   o_uart_start,
    output logic [UART_DATA_W-1:0] o_uart_data_tx,
`ifdef UART_TX_FIFO_OVF_EN
    output logic                   o_ovf,
    input  logic                   i_ovf_clr,
`endif
    output logic                   o_busy
);

    uart_tx_state_e         r_state;
    uart_tx_state_e         w_state_nxt;
    logic                   w_load;
    logic                   w_start_nxt;
    logic                   r_start;
    logic [UART_DATA_W-1:0] r_data_tx;
    logic [UART_DATA_W-1:0] w_rd_data;
    logic                   w_full;
    logic                   w_empty;

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_pop     (w_load),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Next-state decode; the pop and the DATA_TX load share the IDLE->STRT transition.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && i_uart_ready_tx) begin
                    w_load      = 1'b1;
                    w_start_nxt = 1'b1;
                    w_state_nxt = STRT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STRT: begin
                w_state_nxt = ACK;
            end
            ACK: begin
                if (!i_uart_ready_tx) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ACK;
                end
            end
            DONE: begin
                if (i_uart_ready_tx) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, START pulse and held transmit byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_data_tx <= {UART_DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            if (w_load) begin
                r_data_tx <= w_rd_data;
            end else begin
                r_data_tx <= r_data_tx;
            end
        end
    end

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_uart_start   = r_start;
    assign o_uart_data_tx = r_data_tx;
    assign o_busy         = (r_state != IDLE) || !w_empty;

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // Sticky overflow: a dropped push in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (i_wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule
